// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed hex display driver with frame-synchronous loading, PWM dimming and dead time
module seg_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int PWM_BITS    = 4,
    parameter int BLANK_CYC   = 2,
    localparam int SEL_W      = $clog2(NUM_DIGITS),
    localparam int PRE_W      = $clog2(REFRESH_DIV)
) (
    input  logic                    clkin,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    input  logic [PWM_BITS-1:0]     brightness,
    output logic                    load_done,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              cathode,
    output logic                    dp,
    output logic [SEL_W-1:0]        digit_sel,
    output logic                    frame_tick
);

    logic [PRE_W-1:0]        pre_cnt;
    logic [PWM_BITS-1:0]     pwm_cnt;
    logic [4*NUM_DIGITS-1:0] stg_data, act_data;
    logic [NUM_DIGITS-1:0]   stg_dp, act_dp, stg_blank, act_blank;
    logic                    pending, pre_last, boundary, apply, en;
    logic [3:0]              nib;
    logic [6:0]              seg;

    assign pre_last = pre_cnt == PRE_W'(REFRESH_DIV - 1);
    assign boundary = pre_last && digit_sel == SEL_W'(NUM_DIGITS - 1);
    // a load landing on the boundary itself wins; its data goes out one frame later
    assign apply    = boundary && pending && !load;
    assign nib      = act_data[4*digit_sel +: 4];
    // the last prescaler cycle is kept dark too, so the registered anode is already off
    // in the first output cycle of a slot, when digit_sel has moved to the next digit
    assign en       = pre_cnt >= PRE_W'(BLANK_CYC) && !pre_last && pwm_cnt <= brightness
                      && !act_blank[digit_sel];

    // active-low hex decode, bit order {g,f,e,d,c,b,a}
    always_comb begin
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
    end

    // prescaler, PWM counter, digit rotation and the frame/load pulses
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            pre_cnt    <= '0;
            pwm_cnt    <= '0;
            digit_sel  <= '0;
            frame_tick <= 1'b0;
            load_done  <= 1'b0;
        end else begin
            pre_cnt    <= pre_last ? '0 : pre_cnt + 1'b1;
            pwm_cnt    <= pwm_cnt + 1'b1;
            if (pre_last)
                digit_sel <= boundary ? '0 : digit_sel + 1'b1;
            frame_tick <= boundary;
            load_done  <= apply;
        end
    end

    // staging/active double buffer so a frame never shows a mix of old and new data
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            stg_data  <= '0;
            stg_dp    <= '0;
            stg_blank <= '1;
            act_data  <= '0;
            act_dp    <= '0;
            act_blank <= '1;
            pending   <= 1'b0;
        end else begin
            if (load) begin
                stg_data  <= digit_data;
                stg_dp    <= dp_in;
                stg_blank <= blank_in;
            end
            if (apply) begin
                act_data  <= stg_data;
                act_dp    <= stg_dp;
                act_blank <= stg_blank;
            end
            pending <= load ? 1'b1 : apply ? 1'b0 : pending;
        end
    end

    // registered pin drive; segments are released whenever the digit is off
    always_ff @(posedge clkin or negedge reset) begin
        if (!reset) begin
            anode   <= '1;
            cathode <= '1;
            dp      <= 1'b1;
        end else begin
            anode   <= en ? ~(NUM_DIGITS'(1) << digit_sel) : '1;
            cathode <= en ? seg : '1;
            dp      <= en ? ~act_dp[digit_sel] : 1'b1;
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed table-driven bench for seg_scan_driver (4 digits, 8-cycle slots)
module tb_seg_scan_driver;

    logic        clkin = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] digit_data = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_in = '0;
    logic        load = 1'b0;
    logic [1:0]  brightness = 2'd3;
    logic        load_done;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        dp;
    logic [1:0]  digit_sel;
    logic        frame_tick;

    int n_chk = 0;
    int n_fail = 0;

    seg_scan_driver #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .PWM_BITS(2), .BLANK_CYC(1)
    ) dut (
        .clkin(clkin), .reset(reset), .digit_data(digit_data), .dp_in(dp_in),
        .blank_in(blank_in), .load(load), .brightness(brightness),
        .load_done(load_done), .anode(anode), .cathode(cathode), .dp(dp),
        .digit_sel(digit_sel), .frame_tick(frame_tick)
    );

    always #5 clkin = ~clkin;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dpv;
        logic [3:0]  blk;
        int          sel;
        logic [3:0]  an;
        logic [6:0]  cat;
        logic        dpo;
    } vec_t;

    vec_t tv[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clkin);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    // steps until frame_tick (which=0) or load_done (which=1) is seen, at most 40 cycles
    task automatic wait_flag(input int which, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (((which == 0) ? !frame_tick : !load_done) && cnt < 40);
    endtask

    task automatic wait_frame();
        int c;
        wait_flag(0, c);
        chk("frame_sync", frame_tick, 1);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        digit_data = d;
        dp_in = p;
        blank_in = b;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic count_lit(output int lit);
        lit = 0;
        repeat (32) begin
            step();
            if (anode !== 4'hF) lit++;
        end
    endtask

    initial begin
        int c, lit;
        int exp_lit[4];
        exp_lit = '{4, 12, 20, 24};
        tv[0]  = '{16'h3A70, 4'b0100, 4'b0000, 0, 4'b1110, 7'h40, 1'b1};
        tv[1]  = '{16'h3A70, 4'b0100, 4'b0000, 1, 4'b1101, 7'h78, 1'b1};
        tv[2]  = '{16'h3A70, 4'b0100, 4'b0000, 2, 4'b1011, 7'h08, 1'b0};
        tv[3]  = '{16'h3A70, 4'b0100, 4'b0000, 3, 4'b0111, 7'h30, 1'b1};
        tv[4]  = '{16'h9B2E, 4'b0001, 4'b0000, 0, 4'b1110, 7'h06, 1'b0};
        tv[5]  = '{16'h9B2E, 4'b0001, 4'b0000, 1, 4'b1101, 7'h24, 1'b1};
        tv[6]  = '{16'h9B2E, 4'b0001, 4'b0000, 2, 4'b1011, 7'h03, 1'b1};
        tv[7]  = '{16'h9B2E, 4'b0001, 4'b0000, 3, 4'b0111, 7'h10, 1'b1};
        tv[8]  = '{16'h1D56, 4'b1000, 4'b0000, 0, 4'b1110, 7'h02, 1'b1};
        tv[9]  = '{16'h1D56, 4'b1000, 4'b0000, 1, 4'b1101, 7'h12, 1'b1};
        tv[10] = '{16'h1D56, 4'b1000, 4'b0000, 2, 4'b1011, 7'h21, 1'b1};
        tv[11] = '{16'h1D56, 4'b1000, 4'b0000, 3, 4'b0111, 7'h79, 1'b0};
        tv[12] = '{16'h8FC4, 4'b0000, 4'b0000, 0, 4'b1110, 7'h19, 1'b1};
        tv[13] = '{16'h8FC4, 4'b0000, 4'b0000, 1, 4'b1101, 7'h46, 1'b1};
        tv[14] = '{16'h8FC4, 4'b0000, 4'b0000, 2, 4'b1011, 7'h0E, 1'b1};
        tv[15] = '{16'h8FC4, 4'b0000, 4'b0000, 3, 4'b0111, 7'h00, 1'b1};
        tv[16] = '{16'h3A70, 4'b0100, 4'b0010, 0, 4'b1110, 7'h40, 1'b1};
        tv[17] = '{16'h3A70, 4'b0100, 4'b0010, 1, 4'b1111, 7'h7F, 1'b1};
        tv[18] = '{16'h3A70, 4'b0100, 4'b0010, 2, 4'b1011, 7'h08, 1'b0};

        // reset held with the clock running
        steps(3);
        chk("rst_anode", anode, 4'hF);
        chk("rst_cathode", cathode, 7'h7F);
        chk("rst_dp", dp, 1);
        chk("rst_digit_sel", digit_sel, 0);
        chk("rst_frame_tick", frame_tick, 0);
        chk("rst_load_done", load_done, 0);
        reset = 1'b1;
        wait_flag(0, c);
        chk("first_frame_latency", c, 32);
        wait_flag(0, c);
        chk("frame_period", c, 32);
        chk("frame_sel0", digit_sel, 0);
        count_lit(lit);
        chk("dark_after_reset", lit, 0);

        // rotation / decode / blanking vectors
        for (int i = 0; i < 19; i++) begin
            if (i == 0 || tv[i].data != tv[i-1].data || tv[i].dpv != tv[i-1].dpv || tv[i].blk != tv[i-1].blk) begin
                do_load(tv[i].data, tv[i].dpv, tv[i].blk);
                wait_flag(1, c);
                chk("vec_load_done", load_done, 1);
                chk("vec_done_with_tick", frame_tick, 1);
            end else begin
                wait_frame();
            end
            steps(tv[i].sel * 8);
            chk("dead_off0_anode", anode, 4'hF);
            chk("dead_off0_cathode", cathode, 7'h7F);
            step();
            chk("dead_off1_anode", anode, 4'hF);
            chk("dead_off1_dp", dp, 1);
            steps(3);
            chk("vec_sel", digit_sel, tv[i].sel);
            chk("vec_anode", anode, tv[i].an);
            chk("vec_cathode", cathode, tv[i].cat);
            chk("vec_dp", dp, tv[i].dpo);
        end

        // brightness: lit cycles per frame, and the single lit cycle at brightness 0
        do_load(16'h8FC4, 4'b0000, 4'b0000);
        wait_flag(1, c);
        chk("bright_load_done", load_done, 1);
        for (int b = 0; b < 4; b++) begin
            brightness = 2'(b);
            count_lit(lit);
            chk("bright_lit_count", lit, exp_lit[b]);
        end
        brightness = 2'd0;
        steps(4);
        chk("bright0_off4", anode, 4'hF);
        step();
        chk("bright0_off5", anode, 4'b1110);
        brightness = 2'd3;

        // load handshake: two loads mid-frame, last one wins at the next frame
        wait_frame();
        steps(5);
        do_load(16'h1234, 4'b0000, 4'b0000);
        step();
        do_load(16'h5678, 4'b0000, 4'b0000);
        steps(12);
        chk("hs_old_frame", cathode, 7'h0E);
        wait_flag(1, c);
        chk("hs_latency", c, 12);
        chk("hs_done_with_tick", frame_tick, 1);
        step();
        chk("hs_done_one_cycle", load_done, 0);
        steps(3);
        chk("hs_d0", cathode, 7'h00);
        steps(8);
        chk("hs_d1", cathode, 7'h78);
        steps(16);
        chk("hs_d3", cathode, 7'h12);
        chk("hs_d3_anode", anode, 4'b0111);

        // boundary collision: a load on the boundary cycle defers the transfer
        wait_frame();
        steps(4);
        do_load(16'hAAAA, 4'b0000, 4'b0000);
        steps(26);
        do_load(16'h4444, 4'b0000, 4'b0000);
        chk("bc_tick", frame_tick, 1);
        chk("bc_no_done", load_done, 0);
        steps(4);
        chk("bc_still_old", cathode, 7'h00);
        wait_flag(1, c);
        chk("bc_deferred_latency", c, 28);
        chk("bc_done_with_tick", frame_tick, 1);
        steps(12);
        chk("bc_new_data", cathode, 7'h19);
        chk("bc_new_anode", anode, 4'b1101);

        // asynchronous reset in the middle of digit 2
        wait_frame();
        steps(20);
        chk("mr_before", anode, 4'b1011);
        #1 reset = 1'b0;
        #1;
        chk("mr_anode", anode, 4'hF);
        chk("mr_cathode", cathode, 7'h7F);
        chk("mr_dp", dp, 1);
        chk("mr_digit_sel", digit_sel, 0);
        chk("mr_frame_tick", frame_tick, 0);
        chk("mr_load_done", load_done, 0);
        steps(2);
        reset = 1'b1;
        wait_flag(0, c);
        chk("mr_first_frame", c, 32);
        count_lit(lit);
        chk("mr_dark", lit, 0);
        do_load(16'h3A70, 4'b0100, 4'b0000);
        wait_flag(1, c);
        chk("mr_reload_done", load_done, 1);
        steps(4);
        chk("mr_reload_anode", anode, 4'b1110);
        chk("mr_reload_cathode", cathode, 7'h40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
